mem_block_mover: RTL and testbench

- Memory-interface initiator that drives adr/d_in/mrd/mwr into the byte-addressed word memory and consumes its d_out.
- Copies a block of 32-bit words from a source byte address to a destination byte address.
- Copying starts on a start pulse and reports done when finished.
- Sits beside the multicycle datapath as a block-copy engine for initialising data regions and relocating result blocks.

---
 rtl/mem_if_pkg.sv | 16 +
 rtl/mem_block_mover.sv | 116 +++++++++++
 tb/tb_mem_block_mover.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_if_pkg.sv
// Shared definitions for initiators of the byte-addressed word memory:
// FSM encoding, word stride and default bus widths.
package mem_if_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mem_block_mover.sv
// Block-copy engine: reads a word from src, writes it to dst, two cycles per
// word, ascending addresses, one-cycle done pulse at the end.
module mem_block_mover
    import mem_if_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_adr,
    input  logic [ADDR_W-1:0] dst_adr,
    input  logic [CNT_W-1:0]  word_cnt,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  words_done,
    output logic [ADDR_W-1:0] adr,
    output logic [DATA_W-1:0] d_in,
    output logic              mrd,
    output logic              mwr,
    input  logic [DATA_W-1:0] d_out
);

    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(WORD_BYTES);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_ptr_q, src_ptr_d;
    logic [ADDR_W-1:0] dst_ptr_q, dst_ptr_d;
    logic [CNT_W-1:0]  remain_q, remain_d;
    logic [CNT_W-1:0]  words_done_q, words_done_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            src_ptr_q    <= '0;
            dst_ptr_q    <= '0;
            remain_q     <= '0;
            words_done_q <= '0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            src_ptr_q    <= src_ptr_d;
            dst_ptr_q    <= dst_ptr_d;
            remain_q     <= remain_d;
            words_done_q <= words_done_d;
            data_q       <= data_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        src_ptr_d    = src_ptr_q;
        dst_ptr_d    = dst_ptr_q;
        remain_d     = remain_q;
        words_done_d = words_done_q;
        data_d       = data_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    src_ptr_d    = src_adr;
                    dst_ptr_d    = dst_adr;
                    remain_d     = word_cnt;
                    words_done_d = '0;
                    state_d      = (word_cnt != '0) ? READ : DONE;
                end
            end
            READ: begin
                data_d    = d_out;
                src_ptr_d = src_ptr_q + STRIDE;
                state_d   = WRITE;
            end
            WRITE: begin
                dst_ptr_d    = dst_ptr_q + STRIDE;
                remain_d     = remain_q - CNT_W'(1);
                words_done_d = words_done_q + CNT_W'(1);
                // remain still holds the pre-decrement count here
                state_d      = (remain_q == CNT_W'(1)) ? DONE : READ;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Moore outputs: all decoded from registered state so they drop with rst
    always_comb begin
        adr = '0;
        mrd = 1'b0;
        mwr = 1'b0;
        case (state_q)
            READ: begin
                adr = src_ptr_q;
                mrd = 1'b1;
            end
            WRITE: begin
                adr = dst_ptr_q;
                mwr = 1'b1;
            end
            default: begin
                adr = '0;
            end
        endcase
    end

    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign words_done = words_done_q;
    assign d_in       = data_q;

endmodule

// File: tb/tb_mem_block_mover.sv
// Scoreboard bench: directed copy jobs against a byte-addressed memory model;
// a negedge monitor checks every read, write and done pulse against queued expectations.
module tb_mem_block_mover;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] src_adr = '0;
    logic [31:0] dst_adr = '0;
    logic [15:0] word_cnt = '0;
    logic        busy, done, mrd, mwr;
    logic [15:0] words_done;
    logic [31:0] adr, d_in, d_out;

    logic        tb_we = 1'b0;
    logic [31:0] tb_wadr = '0;
    logic [31:0] tb_wdata = '0;

    bit [7:0] mem [0:4095];

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_rd[$];
    wr_t         exp_wr[$];
    logic [15:0] exp_done[$];

    always #5 clk = ~clk;

    mem_block_mover dut (
        .clk(clk), .rst(rst), .start(start),
        .src_adr(src_adr), .dst_adr(dst_adr), .word_cnt(word_cnt),
        .busy(busy), .done(done), .words_done(words_done),
        .adr(adr), .d_in(d_in), .mrd(mrd), .mwr(mwr), .d_out(d_out)
    );

    // 4 KiB byte memory, little-endian words, address wraps on the low 12 bits
    assign d_out = {mem[adr[11:0] + 12'd3], mem[adr[11:0] + 12'd2],
                    mem[adr[11:0] + 12'd1], mem[adr[11:0]]};

    always @(posedge clk) begin
        if (mwr) begin
            for (int b = 0; b < 4; b++) mem[adr[11:0] + 12'(b)] <= d_in[8*b +: 8];
        end else if (tb_we) begin
            for (int b = 0; b < 4; b++) mem[tb_wadr[11:0] + 12'(b)] <= tb_wdata[8*b +: 8];
        end
    end

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        return {mem[a[11:0] + 12'd3], mem[a[11:0] + 12'd2], mem[a[11:0] + 12'd1], mem[a[11:0]]};
    endfunction

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    function automatic void unexpected(input string nm, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: unexpected event, value %h, expected none", nm, act);
    endfunction

    // Monitor: pops expectations whenever the DUT presents a read, write or done
    always @(negedge clk) begin
        if (!rst) begin
            if (mrd && mwr) unexpected("mrd_mwr_both", adr);
            if (mrd) begin
                if (exp_rd.size() == 0) unexpected("rd_adr", adr);
                else chk("rd_adr", adr, exp_rd.pop_front());
            end
            if (mwr) begin
                if (exp_wr.size() == 0) unexpected("wr", d_in);
                else begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    chk("wr_adr", adr, w.adr);
                    chk("wr_data", d_in, w.data);
                end
            end
            if (done) begin
                if (exp_done.size() == 0) unexpected("done", 32'(words_done));
                else chk("done_words", 32'(words_done), 32'(exp_done.pop_front()));
            end
        end
    end

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        @(negedge clk);
        tb_we = 1'b1; tb_wadr = a; tb_wdata = v;
        @(posedge clk); #1;
        tb_we = 1'b0;
    endtask

    task automatic expect_word(input logic [31:0] ra, input logic [31:0] wa, input logic [31:0] v);
        exp_rd.push_back(ra);
        exp_wr.push_back('{adr: wa, data: v});
    endtask

    // Returns with the acceptance edge just past (#1 after it)
    task automatic pulse_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
        @(posedge clk); #1;
        start = 1'b1; src_adr = s; dst_adr = d; word_cnt = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts edges from acceptance (edge 1) until done, plus busy cycles
    task automatic wait_done(output int edges, output int busy_cnt);
        edges = 1;
        busy_cnt = busy ? 1 : 0;
        while (!done && edges < 200) begin
            @(posedge clk); #1;
            edges++;
            if (busy) busy_cnt++;
        end
        if (!done) unexpected("done_timeout", 32'(edges));
    endtask

    task automatic run_job(input string nm, input logic [31:0] s, input logic [31:0] d,
                           input logic [15:0] n);
        int edges, bc;
        exp_done.push_back(n);
        pulse_start(s, d, n);
        wait_done(edges, bc);
        chk({nm, "_latency"}, 32'(edges), 32'(2 * n + 1));
        chk({nm, "_busy_cycles"}, 32'(bc), 32'(2 * n + 1));
        @(posedge clk); #1;
        chk({nm, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int edges, bc;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_mrd_mwr", {30'd0, mrd, mwr}, 32'd0);
        chk("rst_adr", adr, 32'd0);
        chk("rst_d_in", d_in, 32'd0);
        chk("rst_words_done", 32'(words_done), 32'd0);

        preload(32'd1000, 32'h11111111);
        preload(32'd1004, 32'h22222222);
        preload(32'd1008, 32'h33333333);
        for (int i = 0; i < 4; i++) preload(32'd1100 + 32'(4 * i), 32'hA0A0A001 + 32'(i));
        for (int i = 0; i < 5; i++) preload(32'd3000 + 32'(4 * i), 32'h55000001 + 32'(i));
        preload(32'hFFFFFFFC, 32'hDEADBEEF);
        preload(32'h00000000, 32'hCAFEF00D);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic 3-word copy
        expect_word(32'd1000, 32'd2000, 32'h11111111);
        expect_word(32'd1004, 32'd2004, 32'h22222222);
        expect_word(32'd1008, 32'd2008, 32'h33333333);
        run_job("copy3", 32'd1000, 32'd2000, 16'd3);
        chk("copy3_m0", rd_word(32'd2000), 32'h11111111);
        chk("copy3_m1", rd_word(32'd2004), 32'h22222222);
        chk("copy3_m2", rd_word(32'd2008), 32'h33333333);
        repeat (3) @(posedge clk);
        #1 chk("copy3_words_hold", 32'(words_done), 32'd3);

        // Zero-length job: done next cycle, no memory traffic
        run_job("cnt0", 32'd1000, 32'd2400, 16'd0);
        chk("cnt0_words", 32'(words_done), 32'd0);
        chk("cnt0_no_write", rd_word(32'd2400), 32'd0);

        // Start during a running job is ignored
        for (int i = 0; i < 4; i++)
            expect_word(32'd1100 + 32'(4 * i), 32'd2100 + 32'(4 * i), 32'hA0A0A001 + 32'(i));
        exp_done.push_back(16'd4);
        pulse_start(32'd1100, 32'd2100, 16'd4);
        @(posedge clk); #1;
        start = 1'b1; src_adr = 32'd1000; dst_adr = 32'd2200; word_cnt = 16'd2;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(edges, bc);
        repeat (10) @(posedge clk);
        #1;
        chk("ign_busy", 32'(busy), 32'd0);
        chk("ign_m3", rd_word(32'd2112), 32'hA0A0A004);
        chk("ign_no_2nd", rd_word(32'd2200), 32'd0);

        // Reset in the WRITE of word 2 of 5
        expect_word(32'd3000, 32'd2500, 32'h55000001);
        exp_rd.push_back(32'd3004);
        pulse_start(32'd3000, 32'd2500, 16'd5);
        repeat (3) @(posedge clk);
        #1 chk("abort_in_write", 32'(mwr), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("abort_mrd_mwr", {30'd0, mrd, mwr}, 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_idle", {30'd0, busy, done}, 32'd0);
        chk("abort_w1", rd_word(32'd2500), 32'h55000001);
        chk("abort_w2", rd_word(32'd2504), 32'd0);

        // Source pointer wraps through zero
        expect_word(32'hFFFFFFFC, 32'd1500, 32'hDEADBEEF);
        expect_word(32'h00000000, 32'd1504, 32'hCAFEF00D);
        run_job("wrap", 32'hFFFFFFFC, 32'd1500, 16'd2);
        chk("wrap_m0", rd_word(32'd1500), 32'hDEADBEEF);
        chk("wrap_m1", rd_word(32'd1504), 32'hCAFEF00D);

        repeat (2) @(posedge clk);
        #1;
        chk("left_rd", 32'(exp_rd.size()), 32'd0);
        chk("left_wr", 32'(exp_wr.size()), 32'd0);
        chk("left_done", 32'(exp_done.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
